// File: rtl/five_input_self_test_if.sv
// Bus between the self-test engine and its surroundings: start/result
// handshake plus the A..E drive and the Y return from the block under test.
interface five_input_self_test_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       d_out;
  logic       e_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [4:0] first_fail_idx;
  logic       first_fail_vld;

  // Board side: issues start, returns Y, observes vectors and results.
  modport master (
    output start, y_in,
    input  a_out, b_out, c_out, d_out, e_out,
    input  busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );

  // Engine side.
  modport slave (
    input  start, y_in,
    output a_out, b_out, c_out, d_out, e_out,
    output busy, done, pass, err_count, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/five_input_self_test.sv
// Self-test engine for 5-input/1-output combinational blocks: sweeps all 32
// vectors, holds each for SETTLE_CYCLES, samples Y and compares it with the
// EXPECTED truth table. Reports pass, error count and first failing vector.
module five_input_self_test #(
  parameter logic [31:0] EXPECTED      = 32'h5555_AAAA,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  five_input_self_test_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [4:0] idx;
  logic [3:0] settle_cnt;
  logic [5:0] err_count;
  logic [4:0] first_fail_idx;
  logic       first_fail_vld;
  logic       mismatch;
  logic       in_sweep;

  // Compare the returned Y against the golden bit for the current vector.
  always_comb begin
    mismatch = (bus.y_in != EXPECTED[idx]);
  end

  // Sweep sequencer: start acceptance, settle timing, sampling and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state          <= ST_DRIVE;
            idx            <= '0;
            settle_cnt     <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 6'd1;
            if (!first_fail_vld) begin
              first_fail_idx <= idx;
              first_fail_vld <= 1'b1;
            end
          end
          if (idx == 5'd31) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state so an async reset clears them without waiting for a clock.
  always_comb begin
    in_sweep            = (state == ST_DRIVE) || (state == ST_SAMPLE);
    bus.busy            = in_sweep;
    bus.done            = (state == ST_DONE);
    bus.pass            = (state == ST_DONE) && (err_count == '0);
    bus.err_count       = err_count;
    bus.first_fail_idx  = first_fail_idx;
    bus.first_fail_vld  = first_fail_vld;
    {bus.a_out, bus.b_out, bus.c_out, bus.d_out, bus.e_out} = in_sweep ? idx : '0;
  end

endmodule
